// File: rtl/pkt_buf_pkg.sv
// Shared widths, descriptor type and FSM encodings for the slot-based packet buffer.
package pkt_buf_pkg;
  localparam int META_W      = 128;
  localparam int ADDR_W      = 11;
  localparam int MAX_BEATS   = 64;
  localparam int NUM_SLOTS_D = (2 ** ADDR_W) / MAX_BEATS;
  localparam int SW          = $clog2(NUM_SLOTS_D);
  localparam int LW          = $clog2(MAX_BEATS) + 1;

  typedef struct packed {
    logic [SW-1:0]     slot;
    logic [LW-1:0]     len;
    logic [META_W-1:0] tuser;
  } desc_t;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_e;
  typedef enum logic       {R_IDLE, R_RUN}         rd_state_e;

  function automatic logic [SW:0] popcount(input logic [NUM_SLOTS_D-1:0] v);
    logic [SW:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS_D; i++) n = n + (SW+1)'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/pkt_buffer_ctrl_if.sv
// AXI-Stream bundle used for both the ingress and egress sides of the packet buffer.
interface pkt_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_buf_free_list.sv
// Free-slot bitmap with lowest-index allocation and two independent release ports.
module pkt_buf_free_list
  import pkt_buf_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_i,
  output logic          alloc_valid_o,
  output logic [SW-1:0] alloc_slot_o,
  input  logic          free_a_i,
  input  logic [SW-1:0] free_a_slot_i,
  input  logic          free_b_i,
  input  logic [SW-1:0] free_b_slot_i,
  output logic [SW:0]   free_cnt_o
);
  logic [NUM_SLOTS-1:0] free_q, free_d;

  // Descending scan so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    alloc_valid_o = 1'b0;
    alloc_slot_o  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_valid_o = 1'b1;
        alloc_slot_o  = SW'(i);
      end
    end
  end

  always_comb begin
    free_d = free_q;
    if (alloc_i)  free_d[alloc_slot_o]  = 1'b0;
    if (free_a_i) free_d[free_a_slot_i] = 1'b1;
    if (free_b_i) free_d[free_b_slot_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) free_q <= '1;
    else     free_q <= free_d;
  end

  assign free_cnt_o = popcount(free_q);
endmodule

// File: rtl/pkt_buffer_ctrl.sv
// Packet buffer controller: stores ingress packets into fixed BRAM slots, issues
// descriptors to the PIFO and replays dequeued slots onto the egress stream.
module pkt_buffer_ctrl
  import pkt_buf_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int SUME_META_WIDTH = META_W,
  parameter int ADDR_WIDTH      = ADDR_W,
  parameter int MAX_PKT_BEATS   = MAX_BEATS
) (
  input  logic                             clk,
  input  logic                             rst,
  pkt_buffer_ctrl_if.slave                 s_axis,
  output logic [SW-1:0]                    desc_slot,
  output logic [LW-1:0]                    desc_len,
  output logic [SUME_META_WIDTH-1:0]       desc_tuser,
  output logic                             desc_valid,
  input  logic                             desc_ready,
  input  logic [SW-1:0]                    deq_slot,
  input  logic [LW-1:0]                    deq_len,
  input  logic                             deq_valid,
  output logic                             deq_ready,
  output logic                             bram_wr_en,
  output logic [ADDR_WIDTH-1:0]            bram_wr_addr,
  output logic [KEEP_WIDTH+DATA_WIDTH-1:0] bram_wr_data,
  output logic                             bram_rd_en,
  output logic [ADDR_WIDTH-1:0]            bram_rd_addr,
  input  logic [KEEP_WIDTH+DATA_WIDTH-1:0] bram_rd_data,
  pkt_buffer_ctrl_if.master                m_axis,
  output logic [SW:0]                      free_slots,
  output logic                             drop_pulse
);
  localparam int BW = KEEP_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic          last;
    logic [SW-1:0] slot;
    logic [BW-1:0] beat;
  } ent_t;

  wr_state_e               w_state_q, w_state_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [LW-1:0]           beat_q, beat_d;
  logic [META_W-1:0]       tuser_q, tuser_d;
  desc_t                   desc_q, desc_d;
  logic                    desc_valid_q, desc_valid_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [BW-1:0]           wr_data_q, wr_data_d;
  logic                    drop_q, drop_d;
  logic                    s_ready, alloc, alloc_valid, free_drop;
  logic [SW-1:0]           alloc_slot;

  rd_state_e               r_state_q, r_state_d;
  logic [SW-1:0]           rd_slot_q, rd_slot_d;
  logic [LW-1:0]           rd_len_q, rd_len_d, rd_idx_q, rd_idx_d;
  logic                    rd_en, rd_last, room, pop, push;
  logic                    fl_vld_q, fl_last_q;
  logic [SW-1:0]           fl_slot_q;
  ent_t                    mem_q [2];
  ent_t                    head;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q;

  pkt_buf_free_list u_free_list (
    .clk           (clk),
    .rst           (rst),
    .alloc_i       (alloc),
    .alloc_valid_o (alloc_valid),
    .alloc_slot_o  (alloc_slot),
    .free_a_i      (free_drop),
    .free_a_slot_i (slot_q),
    .free_b_i      (pop && head.last),
    .free_b_slot_i (head.slot),
    .free_cnt_o    (free_slots)
  );

  // Write path: ingress beats become registered BRAM port-A writes one cycle later.
  always_comb begin
    w_state_d    = w_state_q;
    slot_d       = slot_q;
    beat_d       = beat_q;
    tuser_d      = tuser_q;
    desc_d       = desc_q;
    desc_valid_d = desc_valid_q && !desc_ready;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    drop_d       = 1'b0;
    alloc        = 1'b0;
    free_drop    = 1'b0;
    s_ready      = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        s_ready = alloc_valid && !desc_valid_q;
        if (s_axis.tvalid && s_ready) begin
          alloc     = 1'b1;
          slot_d    = alloc_slot;
          tuser_d   = s_axis.tuser;
          beat_d    = LW'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = {alloc_slot, {(LW-1){1'b0}}};
          wr_data_d = {s_axis.tkeep, s_axis.tdata};
          if (s_axis.tlast) begin
            desc_d.slot  = alloc_slot;
            desc_d.len   = LW'(1);
            desc_d.tuser = s_axis.tuser;
            desc_valid_d = 1'b1;
          end else begin
            w_state_d = W_PKT;
          end
        end
      end
      W_PKT: begin
        s_ready = !desc_valid_q;
        if (s_axis.tvalid && s_ready) begin
          if (beat_q == LW'(MAX_PKT_BEATS)) begin
            // Slot is full: give it back and swallow the rest of the packet.
            free_drop = 1'b1;
            drop_d    = 1'b1;
            w_state_d = s_axis.tlast ? W_IDLE : W_DROP;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = {slot_q, beat_q[LW-2:0]};
            wr_data_d = {s_axis.tkeep, s_axis.tdata};
            beat_d    = beat_q + LW'(1);
            if (s_axis.tlast) begin
              desc_d.slot  = slot_q;
              desc_d.len   = beat_q + LW'(1);
              desc_d.tuser = tuser_q;
              desc_valid_d = 1'b1;
              w_state_d    = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        s_ready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      slot_q       <= '0;
      beat_q       <= '0;
      desc_q       <= '0;
      desc_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      slot_q       <= slot_d;
      beat_q       <= beat_d;
      desc_q       <= desc_d;
      desc_valid_q <= desc_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) tuser_q <= tuser_d;

  // Read path: issue a read only if the 2-entry buffer can absorb it after this cycle's pop.
  assign pop     = (cnt_q != 2'd0) && m_axis.tready;
  assign push    = fl_vld_q;
  assign room    = (3'(cnt_q) + 3'(fl_vld_q) - 3'(pop)) <= 3'd1;
  assign rd_last = (rd_idx_q == rd_len_q - LW'(1));

  always_comb begin
    r_state_d = r_state_q;
    rd_slot_d = rd_slot_q;
    rd_len_d  = rd_len_q;
    rd_idx_d  = rd_idx_q;
    rd_en     = 1'b0;
    deq_ready = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        deq_ready = 1'b1;
        if (deq_valid) begin
          rd_slot_d = deq_slot;
          rd_len_d  = deq_len;
          rd_idx_d  = '0;
          r_state_d = R_RUN;
        end
      end
      R_RUN: begin
        if (room) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + LW'(1);
          if (rd_last) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rd_slot_q <= '0;
      rd_len_q  <= '0;
      rd_idx_q  <= '0;
      fl_vld_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      rd_slot_q <= rd_slot_d;
      rd_len_q  <= rd_len_d;
      rd_idx_q  <= rd_idx_d;
      fl_vld_q  <= rd_en;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    fl_last_q <= rd_last;
    fl_slot_q <= rd_slot_q;
    if (push) mem_q[wr_ptr_q] <= '{last: fl_last_q, slot: fl_slot_q, beat: bram_rd_data};
  end

  assign head          = mem_q[rd_ptr_q];
  assign m_axis.tvalid = (cnt_q != 2'd0);
  assign m_axis.tdata  = m_axis.tvalid ? head.beat[DATA_WIDTH-1:0] : '0;
  assign m_axis.tkeep  = m_axis.tvalid ? head.beat[BW-1:DATA_WIDTH] : '0;
  assign m_axis.tlast  = m_axis.tvalid && head.last;
  assign m_axis.tuser  = '0;

  assign s_axis.tready = s_ready;
  assign desc_slot     = desc_q.slot;
  assign desc_len      = desc_q.len;
  assign desc_tuser    = desc_q.tuser;
  assign desc_valid    = desc_valid_q;
  assign bram_wr_en    = wr_en_q;
  assign bram_wr_addr  = wr_addr_q;
  assign bram_wr_data  = wr_data_q;
  assign bram_rd_en    = rd_en;
  assign bram_rd_addr  = {rd_slot_q, rd_idx_q[LW-2:0]};
  assign drop_pulse    = drop_q;
endmodule

// File: tb/tb_pkt_buffer_ctrl.sv
// Directed bench for pkt_buffer_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_pkt_buffer_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   desc_slot;
  logic [6:0]   desc_len;
  logic [127:0] desc_tuser;
  logic         desc_valid, desc_ready;
  logic [4:0]   deq_slot;
  logic [6:0]   deq_len;
  logic         deq_valid, deq_ready;
  logic         bram_wr_en, bram_rd_en;
  logic [10:0]  bram_wr_addr, bram_rd_addr;
  logic [287:0] bram_wr_data, bram_rd_data;
  logic [5:0]   free_slots;
  logic         drop_pulse;
  logic [287:0] bram [0:2047];

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;
  int last_drop_beat, last_rd_en0, last_lat, last_end;

  pkt_buffer_ctrl_if #(.DATA_WIDTH(256), .KEEP_WIDTH(32), .USER_WIDTH(128)) s_if ();
  pkt_buffer_ctrl_if #(.DATA_WIDTH(256), .KEEP_WIDTH(32), .USER_WIDTH(128)) m_if ();

  pkt_buffer_ctrl dut (
    .clk(clk), .rst(rst), .s_axis(s_if),
    .desc_slot(desc_slot), .desc_len(desc_len), .desc_tuser(desc_tuser),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .deq_slot(deq_slot), .deq_len(deq_len), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .m_axis(m_if), .free_slots(free_slots), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_wr_en) bram[bram_wr_addr] <= bram_wr_data;
    if (bram_rd_en) bram_rd_data <= bram[bram_rd_addr];
  end

  always @(negedge clk) if (drop_pulse) drop_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [255:0] pat(input int tag, input int b);
    return {8{tag[15:0], b[15:0]}};
  endfunction

  function automatic logic [31:0] kp(input int b, input int n);
    return (b == n - 1) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  // Drives one packet; checks each accepted beat's BRAM write in the following cycle.
  task automatic send_pkt(input int n, input int tag, input int es, input logic [127:0] user);
    int b = 0;
    int to = 0;
    int werr = 0;
    last_drop_beat = -1;
    while (b < n && to < 500) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = pat(tag, b);
      s_if.tkeep  = kp(b, n);
      s_if.tlast  = (b == n - 1);
      s_if.tuser  = (b == 0) ? user : 128'hdead_beef;
      if (s_if.tready) begin
        tick();
        b++;
        if (drop_pulse && last_drop_beat < 0) last_drop_beat = b;
        if (b <= 64) begin
          if (bram_wr_en !== 1'b1 || bram_wr_addr !== 11'(es * 64 + b - 1) ||
              bram_wr_data !== {kp(b - 1, n), pat(tag, b - 1)}) werr++;
        end else if (bram_wr_en !== 1'b0) werr++;
      end else begin
        tick();
        to++;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    check("tx_beats", b, n);
    check("tx_wr_errs", werr, 0);
  endtask

  task automatic accept_desc(input int slot, input int len, input logic [127:0] user);
    check("desc_valid", desc_valid, 1);
    check("desc_slot", desc_slot, slot);
    check("desc_len", desc_len, len);
    check("desc_tuser", desc_tuser, user);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    check("desc_clr", desc_valid, 0);
  endtask

  task automatic recv_pkt(input int slot, input int n, input int tag, input bit rnd);
    int got = 0, errs = 0, lastpos = -1, cyc = 0, to = 0;
    logic hold = 1'b0;
    logic rdy;
    logic [255:0] hold_d = '0;
    last_lat = -1;
    last_end = -1;
    deq_slot  = 5'(slot);
    deq_len   = 7'(n);
    deq_valid = 1'b1;
    while (!deq_ready && to < 100) begin tick(); to++; end
    tick();
    deq_valid = 1'b0;
    last_rd_en0 = bram_rd_en;
    cyc = 1;
    while (got < n && cyc < 2000) begin
      if (hold && (!m_if.tvalid || m_if.tdata !== hold_d)) errs++;
      if (m_if.tvalid && last_lat < 0) last_lat = cyc;
      if (m_if.tuser !== '0) errs++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_if.tready = rdy;
      hold = m_if.tvalid && !rdy;
      hold_d = m_if.tdata;
      if (m_if.tvalid && rdy) begin
        if (m_if.tdata !== pat(tag, got) || m_if.tkeep !== kp(got, n) ||
            m_if.tlast !== (got == n - 1)) errs++;
        if (m_if.tlast) lastpos = got;
        last_end = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    m_if.tready = 1'b1;
    tick();
    check("rx_count", got, n);
    check("rx_errs", errs, 0);
    check("rx_lastpos", lastpos, n - 1);
    check("rx_no_extra", m_if.tvalid, 0);
  endtask

  initial begin
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    desc_ready = 1'b0; deq_valid = 1'b0; deq_slot = '0; deq_len = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_free", free_slots, 32);
    check("rst_s_ready", s_if.tready, 1);
    check("rst_desc_valid", desc_valid, 0);
    check("rst_m_valid", m_if.tvalid, 0);
    check("rst_wr_en", bram_wr_en, 0);
    check("rst_rd_en", bram_rd_en, 0);
    check("rst_deq_ready", deq_ready, 1);
    check("rst_m_data", m_if.tdata, 0);

    // Single 3-beat packet
    send_pkt(3, 16'h0011, 0, 128'h1234);
    check("t1_free_alloc", free_slots, 31);
    accept_desc(0, 3, 128'h1234);
    recv_pkt(0, 3, 16'h0011, 1'b0);
    check("t1_rd_en_c1", last_rd_en0, 1);
    check("t1_latency", last_lat, 3);
    check("t1_end_cycle", last_end, 5);
    check("t1_free_back", free_slots, 32);

    // Out-of-order release
    send_pkt(2, 16'h000a, 0, 128'ha);
    accept_desc(0, 2, 128'ha);
    send_pkt(5, 16'h000b, 1, 128'hb);
    accept_desc(1, 5, 128'hb);
    recv_pkt(1, 5, 16'h000b, 1'b0);
    check("t2_no_bubble", last_end, 7);
    check("t2_free_b", free_slots, 31);
    send_pkt(1, 16'h000c, 1, 128'hc);
    accept_desc(1, 1, 128'hc);
    recv_pkt(0, 2, 16'h000a, 1'b0);
    recv_pkt(1, 1, 16'h000c, 1'b0);
    check("t2_free_all", free_slots, 32);

    // Full buffer
    for (int i = 0; i < 32; i++) begin
      send_pkt(1, 100 + i, i, 128'(i));
      accept_desc(i, 1, 128'(i));
    end
    check("t3_free_zero", free_slots, 0);
    check("t3_ready_full", s_if.tready, 0);
    repeat (3) tick();
    check("t3_ready_hold", s_if.tready, 0);
    recv_pkt(5, 1, 105, 1'b0);
    check("t3_ready_back", s_if.tready, 1);
    send_pkt(1, 132, 5, 128'd132);
    accept_desc(5, 1, 128'd132);
    for (int i = 0; i < 32; i++) recv_pkt(i, 1, (i == 5) ? 132 : 100 + i, 1'b0);
    check("t3_free_all", free_slots, 32);

    // Oversize drop
    begin
      int d0;
      d0 = drop_cnt;
      send_pkt(70, 16'h0070, 0, 128'h55);
      check("t4_drop_beat", last_drop_beat, 65);
      check("t4_drop_once", drop_cnt - d0, 1);
      check("t4_no_desc", desc_valid, 0);
      check("t4_free", free_slots, 32);
    end
    send_pkt(1, 16'h0071, 0, 128'h66);
    accept_desc(0, 1, 128'h66);
    recv_pkt(0, 1, 16'h0071, 1'b0);

    // Backpressure on a full-slot packet
    send_pkt(64, 16'h0064, 0, 128'h77);
    accept_desc(0, 64, 128'h77);
    recv_pkt(0, 64, 16'h0064, 1'b1);
    check("t5_free", free_slots, 32);

    // Reset while writing and reading
    send_pkt(10, 16'h0090, 0, 128'h90);
    accept_desc(0, 10, 128'h90);
    m_if.tready = 1'b1;
    deq_slot = 5'd0; deq_len = 7'd10; deq_valid = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = pat(99, 0); s_if.tkeep = '1; s_if.tlast = 1'b0;
    tick();
    deq_valid = 1'b0;
    s_if.tdata = pat(99, 1);
    tick();
    check("t6_mid_wr", bram_wr_en, 1);
    check("t6_mid_rd", bram_rd_en, 1);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    tick();
    check("t6_wr_en", bram_wr_en, 0);
    check("t6_wr_addr", bram_wr_addr, 0);
    check("t6_wr_data", bram_wr_data, 0);
    check("t6_rd_en", bram_rd_en, 0);
    check("t6_m_valid", m_if.tvalid, 0);
    check("t6_m_data", m_if.tdata, 0);
    check("t6_desc_valid", desc_valid, 0);
    check("t6_drop", drop_pulse, 0);
    check("t6_free", free_slots, 32);
    rst = 1'b0;
    tick();
    send_pkt(1, 16'h0007, 0, 128'h88);
    accept_desc(0, 1, 128'h88);
    recv_pkt(0, 1, 16'h0007, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
